// File: rtl/uart_cmd_ctrl_if.sv
// Register-write request bus between the UART command controller and the
// configuration register bank.
//   o_wr_en    : write request, held until accepted
//   o_wr_addr  : register address, stable while o_wr_en=1
//   o_wr_data  : register data, stable while o_wr_en=1
//   i_wr_ready : bank accepts the write when i_wr_ready=1 and o_wr_en=1
interface uart_cmd_ctrl_if;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       i_wr_ready;

  modport master (
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    input  i_wr_ready
  );

  modport slave (
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    output i_wr_ready
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller behind uart_rx. Hunts for HEADER,ADDR,DATA,CHK
// frames (CHK = HEADER^ADDR^DATA), enforces an inter-byte timeout and issues
// one held register write per good frame.
//   clk, rst       : clock, synchronous active-high reset
//   i_rx_data/valid: received byte and its one-cycle strobe
//   wr             : register-write request bus (master side)
//   o_busy         : 1 whenever not hunting for a header
//   o_err_chk      : pulse, checksum mismatch
//   o_err_timeout  : pulse, inter-byte timeout inside a frame
//   o_overrun      : pulse, byte dropped while a write was pending
//   o_frame_count  : completed writes, wrapping
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CLKS = 104160,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  uart_cmd_ctrl_if.master        wr,
  output logic                   o_busy,
  output logic                   o_err_chk,
  output logic                   o_err_timeout,
  output logic                   o_overrun,
  output logic [15:0]            o_frame_count
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int unsigned CNT_W_FULL = 32;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CNT_W_FULL'(TIMEOUT_CLKS - 1));

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             err_chk_q, err_chk_d;
  logic             err_to_q, err_to_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_count_q, frame_count_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      err_chk_q     <= 1'b0;
      err_to_q      <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      err_chk_q     <= err_chk_d;
      err_to_q      <= err_to_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    err_chk_d     = 1'b0;
    err_to_d      = 1'b0;
    overrun_d     = 1'b0;
    frame_count_d = frame_count_q;

    unique case (state_q)
      S_HUNT: begin
        if (i_rx_valid && (i_rx_data == HEADER)) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end

      S_ADDR, S_DATA, S_CHK: begin
        // A byte on the terminal-count cycle wins over the timeout.
        if (i_rx_valid) begin
          cnt_d = '0;
          if (state_q == S_ADDR) begin
            addr_d  = i_rx_data;
            state_d = S_DATA;
          end else if (state_q == S_DATA) begin
            data_d  = i_rx_data;
            state_d = S_CHK;
          end else if (i_rx_data == (HEADER ^ addr_q ^ data_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
            state_d   = S_WRITE;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end
        end else if (cnt_q == CNT_TERM) begin
          err_to_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_HUNT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WRITE: begin
        // Any byte seen here is lost, including one in the accept cycle.
        wr_en_d   = 1'b1;
        overrun_d = i_rx_valid;
        if (wr.i_wr_ready) begin
          wr_en_d       = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = S_HUNT;
        end
      end

      default: begin
        state_d = S_HUNT;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_HUNT);
  end

  assign wr.o_wr_en    = wr_en_q;
  assign wr.o_wr_addr  = wr_addr_q;
  assign wr.o_wr_data  = wr_data_q;
  assign o_busy        = busy_q;
  assign o_err_chk     = err_chk_q;
  assign o_err_timeout = err_to_q;
  assign o_overrun     = overrun_q;
  assign o_frame_count = frame_count_q;

endmodule
